// File: rtl/nn_pkg.sv
// Shared types and helpers for the NN layer engines (hidden and output layers).
package nn_pkg;

  typedef enum logic [2:0] {
    IDLE,
    MAC,
    DRAIN,
    WRITE,
    DONE
  } state_t;

  // Arithmetic shift, then ReLU and saturate to dw unsigned bits (dw <= 31).
  // Callers sign-extend their accumulator to 64 bits and truncate the result.
  function automatic logic [31:0] relu_sat(input logic signed [63:0] acc,
                                           input int unsigned       shift,
                                           input int unsigned       dw);
    logic signed [63:0] s;
    logic signed [63:0] max_v;
    s     = acc >>> shift;
    max_v = (64'sd1 <<< dw) - 64'sd1;
    if (s < 64'sd0)
      return '0;
    else if (s > max_v)
      return max_v[31:0];
    else
      return s[31:0];
  endfunction

endpackage

// File: rtl/mac_unit.sv
// Unsigned-by-signed multiply feeding a wrapping signed accumulator; clr wins over en.
module mac_unit #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_W      = 26
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    en,
  input  logic [DATA_WIDTH-1:0]   a,
  input  logic [DATA_WIDTH-1:0]   b,
  output logic signed [ACC_W-1:0] acc
);

  logic signed [2*DATA_WIDTH:0] prod;
  logic signed [ACC_W-1:0]      prod_ext;

  assign prod     = $signed({1'b0, a}) * $signed(b);
  assign prod_ext = {{(ACC_W-2*DATA_WIDTH-1){prod[2*DATA_WIDTH]}}, prod};

  always_ff @(posedge clk) begin
    if (rst || clr)
      acc <= '0;
    else if (en)
      acc <= acc + prod_ext;
  end

endmodule

// File: rtl/hidden_layer_mac.sv
// Hidden-layer engine: streams input/weight RAMs through a MAC and writes
// ReLU-saturated activations to the hidden-unit RAM, one unit at a time.
module hidden_layer_mac
  import nn_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_INPUTS = 784,
  parameter int NUM_HIDDEN = 32,
  parameter int IN_ADDR_W  = 10,
  parameter int WT_ADDR_W  = 15,
  parameter int HID_ADDR_W = 5,
  parameter int ACC_W      = 26,
  parameter int SHIFT      = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic [IN_ADDR_W-1:0]  in_addr,
  input  logic [DATA_WIDTH-1:0] in_q,
  output logic [WT_ADDR_W-1:0]  wt_addr,
  input  logic [DATA_WIDTH-1:0] wt_q,
  output logic [HID_ADDR_W-1:0] hid_addr,
  output logic [DATA_WIDTH-1:0] hid_data,
  output logic                  hid_we,
  output logic                  busy,
  output logic                  done
);

  localparam logic [IN_ADDR_W-1:0]  LAST_I = IN_ADDR_W'(NUM_INPUTS - 1);
  localparam logic [HID_ADDR_W-1:0] LAST_H = HID_ADDR_W'(NUM_HIDDEN - 1);
  localparam logic [WT_ADDR_W-1:0]  STRIDE = WT_ADDR_W'(NUM_INPUTS);

  state_t                  state;
  logic [IN_ADDR_W-1:0]    i;
  logic [HID_ADDR_W-1:0]   h;
  logic [WT_ADDR_W-1:0]    base;
  logic                    valid;
  logic                    acc_clr;
  logic signed [ACC_W-1:0] acc;

  assign acc_clr = ((state == IDLE) && start) || (state == WRITE);

  mac_unit #(
    .DATA_WIDTH (DATA_WIDTH),
    .ACC_W      (ACC_W)
  ) u_mac (
    .clk (clk),
    .rst (rst),
    .clr (acc_clr),
    .en  (valid),
    .a   (in_q),
    .b   (wt_q),
    .acc (acc)
  );

  // The last product lands at the end of DRAIN, so the write port is decoded
  // from the WRITE state rather than registered a cycle early.
  assign hid_we   = (state == WRITE);
  assign hid_addr = hid_we ? h : '0;
  assign hid_data = hid_we ? DATA_WIDTH'(relu_sat(64'(acc), SHIFT, DATA_WIDTH)) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      i       <= '0;
      h       <= '0;
      base    <= '0;
      in_addr <= '0;
      wt_addr <= '0;
      valid   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      // Data addressed this cycle returns next cycle; valid tracks it.
      valid <= (state == MAC);
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state   <= MAC;
            i       <= '0;
            h       <= '0;
            base    <= '0;
            in_addr <= '0;
            wt_addr <= '0;
            busy    <= 1'b1;
          end
        end
        MAC: begin
          if (i == LAST_I) begin
            state <= DRAIN;
          end else begin
            i       <= i + 1'b1;
            in_addr <= i + 1'b1;
            wt_addr <= wt_addr + 1'b1;
          end
        end
        DRAIN: state <= WRITE;
        WRITE: begin
          i <= '0;
          if (h == LAST_H) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            state   <= MAC;
            h       <= h + 1'b1;
            base    <= base + STRIDE;
            in_addr <= '0;
            wt_addr <= base + STRIDE;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hidden_layer_mac.sv
// Directed bench: small configurations (SHIFT=0 and SHIFT=2) plus one default-size run.
module tb_hidden_layer_mac;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic start_ab = 1'b0;
  logic start_c = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- DUT a: NUM_INPUTS=4, NUM_HIDDEN=2, SHIFT=0 ----------------
  logic [9:0]  in_addr_a;
  logic [14:0] wt_addr_a;
  logic [7:0]  in_q_a, wt_q_a, hid_data_a;
  logic [4:0]  hid_addr_a;
  logic        hid_we_a, busy_a, done_a;
  logic [7:0]  in_mem_a [4];
  logic [7:0]  wt_mem_a [8];

  hidden_layer_mac #(.NUM_INPUTS(4), .NUM_HIDDEN(2), .SHIFT(0)) dut_a (
    .clk(clk), .rst(rst), .start(start_ab),
    .in_addr(in_addr_a), .in_q(in_q_a), .wt_addr(wt_addr_a), .wt_q(wt_q_a),
    .hid_addr(hid_addr_a), .hid_data(hid_data_a), .hid_we(hid_we_a),
    .busy(busy_a), .done(done_a));

  always @(posedge clk) begin
    in_q_a <= in_mem_a[in_addr_a[1:0]];
    wt_q_a <= wt_mem_a[wt_addr_a[2:0]];
  end

  // ---------------- DUT b: NUM_INPUTS=4, NUM_HIDDEN=2, SHIFT=2 ----------------
  logic [9:0]  in_addr_b;
  logic [14:0] wt_addr_b;
  logic [7:0]  in_q_b, wt_q_b, hid_data_b;
  logic [4:0]  hid_addr_b;
  logic        hid_we_b, busy_b, done_b;
  logic [7:0]  in_mem_b [4];
  logic [7:0]  wt_mem_b [8];

  hidden_layer_mac #(.NUM_INPUTS(4), .NUM_HIDDEN(2), .SHIFT(2)) dut_b (
    .clk(clk), .rst(rst), .start(start_ab),
    .in_addr(in_addr_b), .in_q(in_q_b), .wt_addr(wt_addr_b), .wt_q(wt_q_b),
    .hid_addr(hid_addr_b), .hid_data(hid_data_b), .hid_we(hid_we_b),
    .busy(busy_b), .done(done_b));

  always @(posedge clk) begin
    in_q_b <= in_mem_b[in_addr_b[1:0]];
    wt_q_b <= wt_mem_b[wt_addr_b[2:0]];
  end

  // ---------------- DUT c: default parameters ----------------
  logic [9:0]  in_addr_c;
  logic [14:0] wt_addr_c;
  logic [7:0]  in_q_c, wt_q_c, hid_data_c;
  logic [4:0]  hid_addr_c;
  logic        hid_we_c, busy_c, done_c;
  logic [7:0]  in_mem_c [1024];
  logic [7:0]  wt_mem_c [32768];

  hidden_layer_mac dut_c (
    .clk(clk), .rst(rst), .start(start_c),
    .in_addr(in_addr_c), .in_q(in_q_c), .wt_addr(wt_addr_c), .wt_q(wt_q_c),
    .hid_addr(hid_addr_c), .hid_data(hid_data_c), .hid_we(hid_we_c),
    .busy(busy_c), .done(done_c));

  always @(posedge clk) begin
    in_q_c <= in_mem_c[in_addr_c];
    wt_q_c <= wt_mem_c[wt_addr_c];
  end

  // ---------------- write / done monitors ----------------
  logic [4:0] wa_a[$], wa_b[$], wa_c[$];
  logic [7:0] wd_a[$], wd_b[$], wd_c[$];
  int done_cnt_a = 0;

  always @(negedge clk) begin
    if (hid_we_a) begin wa_a.push_back(hid_addr_a); wd_a.push_back(hid_data_a); end
    if (hid_we_b) begin wa_b.push_back(hid_addr_b); wd_b.push_back(hid_data_b); end
    if (hid_we_c) begin wa_c.push_back(hid_addr_c); wd_c.push_back(hid_data_c); end
    if (done_a) done_cnt_a++;
  end

  task automatic clear_logs();
    wa_a.delete(); wd_a.delete();
    wa_b.delete(); wd_b.delete();
    wa_c.delete(); wd_c.delete();
    done_cnt_a = 0;
  endtask

  task automatic load_a(input int in0, in1, in2, in3,
                        input int w00, w01, w02, w03, w10, w11, w12, w13);
    in_mem_a[0] = 8'(in0); in_mem_a[1] = 8'(in1); in_mem_a[2] = 8'(in2); in_mem_a[3] = 8'(in3);
    wt_mem_a[0] = 8'(w00); wt_mem_a[1] = 8'(w01); wt_mem_a[2] = 8'(w02); wt_mem_a[3] = 8'(w03);
    wt_mem_a[4] = 8'(w10); wt_mem_a[5] = 8'(w11); wt_mem_a[6] = 8'(w12); wt_mem_a[7] = 8'(w13);
  endtask

  // Pulse start_ab, then wait for done_a; cyc counts edges from the edge start was driven after.
  task automatic run_ab(output int cyc, output bit timed_out);
    @(posedge clk); #1 start_ab = 1'b1;
    @(posedge clk); cyc = 1; #1 start_ab = 1'b0;
    while (!done_a && cyc < 200) begin
      @(posedge clk); cyc++; #1;
    end
    timed_out = !done_a;
  endtask

  task automatic wait_done_a(output bit timed_out);
    int k = 0;
    while (!done_a && k < 200) begin
      @(posedge clk); k++; #1;
    end
    timed_out = !done_a;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if ({busy_a, done_a, hid_we_a} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got %b want 000", {busy_a, done_a, hid_we_a}); end
    n_checks++; if (hid_addr_a !== 5'd0 || hid_data_a !== 8'd0) begin n_fail++; $display("FAIL reset_hid got addr=%0d data=%0d want 0/0", hid_addr_a, hid_data_a); end
    n_checks++; if (in_addr_a !== 10'd0 || wt_addr_a !== 15'd0) begin n_fail++; $display("FAIL reset_addr got in=%0d wt=%0d want 0/0", in_addr_a, wt_addr_a); end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int cyc; bit to;
    load_a(1, 2, 3, 4,  1, 1, 1, 1,  2, 0, 0, 1);
    clear_logs();
    run_ab(cyc, to);
    n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL basic_timeout got timeout=%0d want 0", to); end
    n_checks++; if (cyc !== 13) begin n_fail++; $display("FAIL basic_latency got %0d want 13", cyc); end
    n_checks++; if (wa_a.size() !== 2) begin n_fail++; $display("FAIL basic_nwrites got %0d want 2", wa_a.size()); end
    else begin
      n_checks++; if (wa_a[0] !== 5'd0 || wd_a[0] !== 8'd10) begin n_fail++; $display("FAIL basic_w0 got (%0d,%0d) want (0,10)", wa_a[0], wd_a[0]); end
      n_checks++; if (wa_a[1] !== 5'd1 || wd_a[1] !== 8'd6) begin n_fail++; $display("FAIL basic_w1 got (%0d,%0d) want (1,6)", wa_a[1], wd_a[1]); end
    end
    @(posedge clk); #1;
    n_checks++; if (busy_a !== 1'b0 || done_a !== 1'b0) begin n_fail++; $display("FAIL basic_idle got busy=%b done=%b want 0/0", busy_a, done_a); end
  endtask

  task automatic test_saturate_relu();
    int cyc; bit to;
    load_a(255, 255, 255, 255,  127, 127, 127, 127,  -1, -1, -1, -1);
    clear_logs();
    run_ab(cyc, to);
    @(posedge clk); #1;
    n_checks++; if (to !== 1'b0 || wa_a.size() !== 2) begin n_fail++; $display("FAIL sat_nwrites got %0d timeout=%0d want 2/0", wa_a.size(), to); end
    else begin
      n_checks++; if (wd_a[0] !== 8'd255) begin n_fail++; $display("FAIL sat_high got %0d want 255", wd_a[0]); end
      n_checks++; if (wd_a[1] !== 8'd0) begin n_fail++; $display("FAIL relu_neg got %0d want 0", wd_a[1]); end
    end
  endtask

  task automatic test_shift();
    int cyc; bit to;
    for (int unsigned k = 0; k < 4; k++) in_mem_b[k] = 8'd4;
    in_mem_b[0] = 8'd5;
    // unit 0: 5*3 + 4*3*3 = 51, >>>2 = 12; unit 1: 5*(-1) = -5, >>>2 = -2 -> 0
    wt_mem_b[0] = 8'd3; wt_mem_b[1] = 8'd3; wt_mem_b[2] = 8'd3; wt_mem_b[3] = 8'd3;
    wt_mem_b[4] = 8'hFF; wt_mem_b[5] = 8'd0; wt_mem_b[6] = 8'd0; wt_mem_b[7] = 8'd0;
    load_a(1, 2, 3, 4,  1, 1, 1, 1,  2, 0, 0, 1);
    clear_logs();
    run_ab(cyc, to);
    @(posedge clk); #1;
    n_checks++; if (to !== 1'b0 || wa_b.size() !== 2) begin n_fail++; $display("FAIL shift_nwrites got %0d timeout=%0d want 2/0", wa_b.size(), to); end
    else begin
      n_checks++; if (wd_b[0] !== 8'd12) begin n_fail++; $display("FAIL shift_pos got %0d want 12", wd_b[0]); end
      n_checks++; if (wd_b[1] !== 8'd0) begin n_fail++; $display("FAIL shift_neg got %0d want 0", wd_b[1]); end
    end
  endtask

  task automatic test_back_to_back();
    bit to;
    load_a(1, 2, 3, 4,  1, 1, 1, 1,  2, 0, 0, 1);
    clear_logs();
    @(posedge clk); #1 start_ab = 1'b1;
    @(posedge clk); #1 start_ab = 1'b0;
    repeat (2) @(posedge clk);
    #1 start_ab = 1'b1;
    @(posedge clk); #1 start_ab = 1'b0;
    wait_done_a(to);
    n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL b2b_timeout1 got timeout=%0d want 0", to); end
    // start raised during DONE is ignored, then held into IDLE it is accepted
    start_ab = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL b2b_busy_gap got %b want 0", busy_a); end
    @(posedge clk); #1;
    n_checks++; if (busy_a !== 1'b1) begin n_fail++; $display("FAIL b2b_restart got %b want 1", busy_a); end
    start_ab = 1'b0;
    wait_done_a(to);
    @(posedge clk); #1;
    n_checks++; if (to !== 1'b0 || done_cnt_a !== 2) begin n_fail++; $display("FAIL b2b_dones got %0d timeout=%0d want 2/0", done_cnt_a, to); end
    n_checks++; if (wa_a.size() !== 4) begin n_fail++; $display("FAIL b2b_nwrites got %0d want 4", wa_a.size()); end
    else begin
      n_checks++; if (wa_a[0] !== 5'd0 || wa_a[1] !== 5'd1 || wa_a[2] !== 5'd0 || wa_a[3] !== 5'd1)
        begin n_fail++; $display("FAIL b2b_addrs got %0d,%0d,%0d,%0d want 0,1,0,1", wa_a[0], wa_a[1], wa_a[2], wa_a[3]); end
      n_checks++; if (wd_a[2] !== 8'd10 || wd_a[3] !== 8'd6) begin n_fail++; $display("FAIL b2b_data got %0d,%0d want 10,6", wd_a[2], wd_a[3]); end
    end
  endtask

  task automatic test_reset_mid_run();
    int cyc; bit to;
    load_a(1, 2, 3, 4,  1, 1, 1, 1,  2, 0, 0, 1);
    clear_logs();
    @(posedge clk); #1 start_ab = 1'b1;
    @(posedge clk); #1 start_ab = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    n_checks++; if (in_addr_a !== 10'd0 || wt_addr_a !== 15'd4) begin n_fail++; $display("FAIL unit1_base got in=%0d wt=%0d want 0/4", in_addr_a, wt_addr_a); end
    rst = 1'b1;
    @(posedge clk); #1;
    n_checks++; if ({busy_a, done_a, hid_we_a} !== 3'b000 || in_addr_a !== 10'd0 || wt_addr_a !== 15'd0 || hid_addr_a !== 5'd0 || hid_data_a !== 8'd0)
      begin n_fail++; $display("FAIL midrst_outputs got busy=%b done=%b we=%b in=%0d wt=%0d ha=%0d hd=%0d want all 0", busy_a, done_a, hid_we_a, in_addr_a, wt_addr_a, hid_addr_a, hid_data_a); end
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    n_checks++; if (wa_a.size() !== 1 || done_cnt_a !== 0) begin n_fail++; $display("FAIL midrst_writes got writes=%0d dones=%0d want 1/0", wa_a.size(), done_cnt_a); end
    clear_logs();
    run_ab(cyc, to);
    n_checks++; if (to !== 1'b0 || cyc !== 13) begin n_fail++; $display("FAIL rerun_latency got %0d timeout=%0d want 13/0", cyc, to); end
    n_checks++; if (wa_a.size() !== 2) begin n_fail++; $display("FAIL rerun_nwrites got %0d want 2", wa_a.size()); end
    else begin
      n_checks++; if (wd_a[0] !== 8'd10 || wd_a[1] !== 8'd6 || wa_a[1] !== 5'd1) begin n_fail++; $display("FAIL rerun_data got %0d,%0d want 10,6", wd_a[0], wd_a[1]); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_default_random();
    int cyc;
    int exp_v [32];
    for (int unsigned k = 0; k < 784; k++) in_mem_c[k] = 8'($urandom_range(0, 255));
    for (int unsigned k = 0; k < 784 * 32; k++) wt_mem_c[k] = 8'(int'($urandom_range(0, 16)) - 8);
    for (int unsigned hh = 0; hh < 32; hh++) begin
      int acc = 0;
      int s;
      for (int unsigned k = 0; k < 784; k++)
        acc += int'(in_mem_c[k]) * int'($signed(wt_mem_c[hh * 784 + k]));
      s = acc >>> 7;
      exp_v[hh] = (s < 0) ? 0 : (s > 255) ? 255 : s;
    end
    clear_logs();
    @(posedge clk); #1 start_c = 1'b1;
    @(posedge clk); cyc = 1; #1 start_c = 1'b0;
    while (!done_c && cyc < 30000) begin
      @(posedge clk); cyc++; #1;
    end
    n_checks++; if (cyc !== 32 * 786 + 1) begin n_fail++; $display("FAIL dflt_latency got %0d want %0d", cyc, 32 * 786 + 1); end
    n_checks++; if (wa_c.size() !== 32) begin n_fail++; $display("FAIL dflt_nwrites got %0d want 32", wa_c.size()); end
    else begin
      for (int unsigned hh = 0; hh < 32; hh++) begin
        n_checks++;
        if (wa_c[hh] !== 5'(hh) || wd_c[hh] !== 8'(exp_v[hh])) begin
          n_fail++; $display("FAIL dflt_unit%0d got (%0d,%0d) want (%0d,%0d)", hh, wa_c[hh], wd_c[hh], hh, exp_v[hh]);
        end
      end
    end
  endtask

  initial begin
    for (int unsigned k = 0; k < 4; k++) begin in_mem_a[k] = '0; in_mem_b[k] = '0; end
    for (int unsigned k = 0; k < 8; k++) begin wt_mem_a[k] = '0; wt_mem_b[k] = '0; end
    for (int unsigned k = 0; k < 1024; k++) in_mem_c[k] = '0;
    for (int unsigned k = 0; k < 32768; k++) wt_mem_c[k] = '0;
    test_reset();
    test_basic();
    test_saturate_relu();
    test_shift();
    test_back_to_back();
    test_reset_mid_run();
    test_default_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
